// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data RAM between N_REQ requesters (0 = uart,
// 1 = processor, 2 = debug). Arbitration is round-robin. A granted requester
// that also raises lock keeps the port for a burst of at most MAX_LOCK
// consecutive grants. If the burst is cut off at that limit, the sticky
// busy_err flag is set.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req/lock/wrEn   per-requester request, burst hold, write(1)/read(0)
//   addr/dataIn     packed per-requester address / write data (slice i)
//   gnt             one-hot grant, combinational from state and req
//   rvalid/rdata    one-hot read valid one cycle after a read grant; shared data
//   mem_*           RAM side. The RAM has a one-cycle synchronous read.
//   busy_err        sticky: a locked burst was forcibly released
//
// MAX_LOCK must be at least 1.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int N_REQ      = 3,
   parameter int DATA_WIDTH = 48,
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_LOCK   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ-1:0]              lock,
   input  logic [N_REQ-1:0]              wrEn,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   dataIn,
   output logic [N_REQ-1:0]              gnt,
   output logic [N_REQ-1:0]              rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          mem_wrEn,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_dataIn,
   input  logic [DATA_WIDTH-1:0]         mem_dataOut,
   output logic                          busy_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic               busy_err_q, busy_err_d;
   logic [N_REQ-1:0]   rvalid_q, rvalid_d;

   logic [N_REQ-1:0]   gnt_raw;
   logic [IDX_W-1:0]   search_start;
   logic               rr_found;
   logic [IDX_W-1:0]   rr_idx;
   logic               hold;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      wrap_inc = (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   // The counter saturates instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (c == MAX_CNT) ? c : c + 1'b1;
   endfunction

   // Round-robin search. When a lock is released, the search starts just past
   // the owner, so the owner is found only if nobody else is requesting.
   always_comb begin
      search_start = (state_q == LOCKED) ? wrap_inc(owner_q) : rr_ptr_q;
      rr_found     = 1'b0;
      rr_idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!rr_found && req[(int'(search_start) + k) % N_REQ]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'((int'(search_start) + k) % N_REQ);
         end
      end
   end

   // Next-state logic and grant generation.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      busy_err_d = busy_err_q;
      gnt_raw    = '0;
      hold       = (state_q == LOCKED) && req[owner_q] && lock[owner_q];

      if (hold) begin
         gnt_raw[owner_q] = 1'b1;
         lock_cnt_d       = sat_inc(lock_cnt_q);
         if (lock_cnt_d == MAX_CNT) begin
            // Burst too long: force release and move the pointer past the owner.
            state_d    = IDLE;
            busy_err_d = 1'b1;
            rr_ptr_d   = wrap_inc(owner_q);
         end
      end else begin
         state_d = IDLE;
         if (rr_found) begin
            gnt_raw[rr_idx] = 1'b1;
            rr_ptr_d        = wrap_inc(rr_idx);
            if (lock[rr_idx]) begin
               owner_d    = rr_idx;
               lock_cnt_d = CNT_W'(1);
               // A one-cycle limit is used up by the entry grant itself.
               if (MAX_LOCK <= 1) busy_err_d = 1'b1;
               else               state_d    = LOCKED;
            end
         end else if (state_q == LOCKED) begin
            rr_ptr_d = wrap_inc(owner_q);
         end
      end
   end

   // During reset, the grant is forced low regardless of req.
   assign gnt      = rst ? '0 : gnt_raw;
   assign rvalid_d = gnt & ~wrEn;

   always_comb begin
      mem_wrEn   = 1'b0;
      mem_addr   = '0;
      mem_dataIn = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            mem_wrEn   = wrEn[i];
            mem_addr   = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_dataIn = dataIn[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The RAM returns read data one cycle after the grant, which is the same
   // cycle in which rvalid_q is set.
   assign rvalid   = rvalid_q;
   assign rdata    = (|rvalid_q) ? mem_dataOut : '0;
   assign busy_err = busy_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         busy_err_q <= 1'b0;
         rvalid_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         busy_err_q <= busy_err_d;
         rvalid_q   <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int NR  = 3;
   localparam int DW  = 48;
   localparam int AW  = 12;
   localparam int MAX = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req = '0, lock = '0, wrEn = '0;
   logic [NR*AW-1:0]  addr = '0;
   logic [NR*DW-1:0]  dataIn = '0;
   logic [NR-1:0]     gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              mem_wrEn;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_dataIn;
   logic [DW-1:0]     mem_dataOut = '0;
   logic              busy_err;

   mem_port_arbiter #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(MAX)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .wrEn(wrEn), .addr(addr),
      .dataIn(dataIn), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_wrEn(mem_wrEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
      .mem_dataOut(mem_dataOut), .busy_err(busy_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      init_val = {AW'(i), 24'hC0FFEE, ~AW'(i)};
   endfunction

   // RAM with a one-cycle synchronous read.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic          init_en = 1'b1;
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < (1<<AW); i++) ram[i] <= init_val(i);
      end else begin
         if (mem_wrEn) ram[mem_addr] <= mem_dataIn;
         mem_dataOut <= ram[mem_addr];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, built from the arbitration rules.
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   bit            m_locked;
   int            m_owner, m_rr, m_cnt;
   bit            m_busy;
   logic [NR-1:0] m_pend;
   logic [DW-1:0] m_pend_data;

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_busy = 0;
      m_pend = '0; m_pend_data = '0;
   endtask

   // Compare current outputs with the model, then advance the model by one
   // clock and wait for the next falling edge.
   task automatic step();
      int            start, g, a;
      bit            hold;
      logic [NR-1:0] eg;
      logic [NR-1:0] new_pend;
      logic [DW-1:0] new_data;
      start = m_locked ? (m_owner + 1) % NR : m_rr;
      hold  = m_locked && req[m_owner] && lock[m_owner];
      g = -1;
      if (hold) g = m_owner;
      else begin
         for (int k = 0; k < NR; k++) begin
            if (g < 0 && req[(start + k) % NR]) g = (start + k) % NR;
         end
      end
      eg = (g >= 0) ? NR'(1 << g) : '0;
      check("gnt", gnt, eg);
      check("mem_wrEn", mem_wrEn, (g >= 0) ? wrEn[g] : 1'b0);
      check("mem_addr", mem_addr, (g >= 0) ? addr[g*AW +: AW] : '0);
      check("mem_dataIn", mem_dataIn, (g >= 0) ? dataIn[g*DW +: DW] : '0);
      check("rvalid", rvalid, m_pend);
      if (m_pend != '0) check("rdata", rdata, m_pend_data);
      check("busy_err", busy_err, m_busy);

      new_pend = '0; new_data = '0;
      if (g >= 0) begin
         a = int'(addr[g*AW +: AW]);
         if (wrEn[g]) ref_mem[a] = dataIn[g*DW +: DW];
         else begin
            new_pend = NR'(1 << g);
            new_data = ref_mem[a];
         end
      end
      m_pend = new_pend; m_pend_data = new_data;

      if (hold) begin
         m_cnt++;
         if (m_cnt >= MAX) begin
            m_locked = 0; m_busy = 1; m_rr = (m_owner + 1) % NR;
         end
      end else begin
         if (m_locked) m_rr = (m_owner + 1) % NR;
         m_locked = 0;
         if (g >= 0) begin
            m_rr = (g + 1) % NR;
            if (lock[g]) begin
               m_locked = 1; m_owner = g; m_cnt = 1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"}, gnt, 3'b000);
      check({tag, "_rvalid"}, rvalid, 3'b000);
      check({tag, "_rdata"}, rdata, 48'h0);
      check({tag, "_mem_wrEn"}, mem_wrEn, 1'b0);
      check({tag, "_busy_err"}, busy_err, 1'b0);
   endtask

   typedef struct {
      logic [NR-1:0] req, lock, wr;
      logic [NR-1:0] exp_gnt, exp_rv;
   } vec_t;

   vec_t tbl [17];

   initial begin
      // Round robin, then a write followed by a read back, then a 5-cycle lock.
      tbl[0]  = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000};
      tbl[1]  = '{3'b111, 3'b000, 3'b000, 3'b010, 3'b001};
      tbl[2]  = '{3'b111, 3'b000, 3'b000, 3'b100, 3'b010};
      tbl[3]  = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b100};
      tbl[4]  = '{3'b111, 3'b000, 3'b000, 3'b010, 3'b001};
      tbl[5]  = '{3'b111, 3'b000, 3'b000, 3'b100, 3'b010};
      tbl[6]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
      tbl[7]  = '{3'b010, 3'b000, 3'b010, 3'b010, 3'b000};
      tbl[8]  = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b000};
      tbl[9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
      tbl[10] = '{3'b011, 3'b001, 3'b000, 3'b001, 3'b000};
      tbl[11] = '{3'b011, 3'b001, 3'b000, 3'b001, 3'b001};
      tbl[12] = '{3'b011, 3'b001, 3'b000, 3'b001, 3'b001};
      tbl[13] = '{3'b011, 3'b001, 3'b000, 3'b001, 3'b001};
      tbl[14] = '{3'b011, 3'b001, 3'b000, 3'b001, 3'b001};
      tbl[15] = '{3'b011, 3'b000, 3'b000, 3'b010, 3'b001};
      tbl[16] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010};

      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
      model_reset();

      // Reset with every requester asking.
      req = 3'b111;
      @(negedge clk);
      @(negedge clk);
      init_en = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      addr   = {12'h005, 12'h005, 12'h005};
      dataIn = {48'h222, 48'hABC, 48'h111};
      for (int r = 0; r < 17; r++) begin
         req = tbl[r].req; lock = tbl[r].lock; wrEn = tbl[r].wr;
         #1;
         check($sformatf("tbl%0d_gnt", r), gnt, tbl[r].exp_gnt);
         check($sformatf("tbl%0d_rvalid", r), rvalid, tbl[r].exp_rv);
         if (r == 7) begin
            check("wr_mem_wrEn", mem_wrEn, 1'b1);
            check("wr_mem_addr", mem_addr, 12'h005);
         end
         if (r == 9) check("rd_back_rdata", rdata, 48'hABC);
         step();
      end

      // A held lock on requester 2 is cut off after MAX grants.
      req = 3'b101; lock = 3'b100; wrEn = 3'b000;
      for (int c = 1; c <= MAX + 1; c++) begin
         #1;
         if (c <= MAX) begin
            check($sformatf("maxlock_c%0d_gnt", c), gnt, 3'b100);
            check($sformatf("maxlock_c%0d_busy", c), busy_err, 1'b0);
         end else begin
            check("maxlock_release_gnt", gnt, 3'b001);
            check("maxlock_release_busy", busy_err, 1'b1);
         end
         step();
      end
      req = 3'b000; lock = 3'b000;
      #1;
      check("busy_sticky", busy_err, 1'b1);
      step();

      // Reset arrives while a read to requester 1 is pending.
      req = 3'b010;
      #1;
      check("pre_rst_gnt", gnt, 3'b010);
      step();
      rst = 1'b1; req = 3'b110;
      #1;
      check_reset_outputs("midread");
      model_reset();
      @(negedge clk);
      #1;
      check_reset_outputs("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_gnt", gnt, 3'b010);
      step();

      // Randomized bursts checked against the model.
      for (int b = 0; b < 300; b++) begin
         int len;
         logic [NR-1:0] rq, lk;
         len = $urandom_range(1, 20);
         rq  = NR'($urandom);
         lk  = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 3) == 0) rq = NR'($urandom);
            req  = rq;
            lock = lk;
            wrEn = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
               addr[i*AW +: AW]   = AW'($urandom_range(0, 15));
               dataIn[i*DW +: DW] = {16'($urandom), 32'($urandom)};
            end
            if ($urandom_range(0, 299) == 0) begin
               rst = 1'b1;
               #1;
               check_reset_outputs("rand_rst");
               model_reset();
               @(negedge clk);
               rst = 1'b0;
            end
            #1;
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (index 0 = uart, 1 = processor, 2 = debug).
REQ-002 SHALL have parameter DATA_WIDTH, default 48, data memory word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, data memory address width.
REQ-004 SHALL have parameter MAX_LOCK, default 16, maximum consecutive cycles one locked requester may hold the port.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  input  N_REQ  per-requester access request.
REQ-008 SHALL have port lock  input  N_REQ  per-requester burst hold request, valid only with req.
REQ-009 SHALL have port wrEn  input  N_REQ  per-requester write (1) / read (0) select.
REQ-010 SHALL have port addr  input  N_REQ*ADDR_WIDTH  packed per-requester addresses, requester i at slice i.
REQ-011 SHALL have port dataIn  input  N_REQ*DATA_WIDTH  packed per-requester write data.
REQ-012 SHALL have port gnt  output  N_REQ  one-hot access grant, combinational from current state and req.
REQ-013 SHALL have port rvalid  output  N_REQ  one-hot read data valid.
REQ-014 SHALL have port rdata  output  DATA_WIDTH  read data, shared by all requesters.
REQ-015 SHALL have ports mem_wrEn (output 1), mem_addr (output ADDR_WIDTH), mem_dataIn (output DATA_WIDTH), mem_dataOut (input DATA_WIDTH) to the RAM, which has one-cycle synchronous read.
REQ-016 SHALL have port busy_err  output  1  sticky flag, set when a lock is forcibly released.

Function
REQ-017 SHALL grant at most one requester per cycle; gnt[i] high means that cycle's mem_* outputs carry requester i's wrEn/addr/dataIn.
REQ-018 SHALL drive mem_wrEn = 0, mem_addr = 0 and mem_dataIn = 0 when no gnt is asserted.
REQ-019 SHALL use an FSM with states IDLE (round-robin arbitration) and LOCKED (port held by owner).
REQ-020 In IDLE, SHALL grant the first requesting index at or after rr_ptr, searching upward modulo N_REQ.
REQ-021 SHALL set rr_ptr to (granted index + 1) mod N_REQ at the end of every IDLE grant cycle; rr_ptr is unchanged when nothing is granted.
REQ-022 IDLE->LOCKED SHALL occur when the granted requester also has lock high; the owner index is registered and the lock counter is loaded to 1.
REQ-023 In LOCKED, gnt SHALL go only to the owner and only while req[owner] is high; other requesters stall with gnt low.
REQ-024 LOCKED->IDLE SHALL occur when req[owner] or lock[owner] is low; in that cycle, arbitration is IDLE-style from rr_ptr = owner+1.
REQ-025 SHALL increment the lock counter each LOCKED grant cycle; when it reaches MAX_LOCK, the FSM SHALL return to IDLE, set busy_err, and advance rr_ptr past the owner.
REQ-026 The owner may be re-granted on the cycle after a forced release only if no other requester has req high.
REQ-027 For a granted read, rvalid[i] SHALL assert exactly one cycle after gnt[i] and rdata SHALL equal mem_dataOut in that cycle; a granted write SHALL produce no rvalid.
REQ-028 Back-to-back reads by different requesters SHALL produce back-to-back rvalid pulses in grant order, one per cycle.
REQ-029 SHALL ignore lock bits with req low; a requester that drops req is neither granted nor penalised.
REQ-030 The lock counter SHALL be ceil(log2(MAX_LOCK+1)) bits wide, shall never wrap, and shall saturate at MAX_LOCK.

Reset
REQ-031 While rst is high: state = IDLE, rr_ptr = 0, owner = 0, lock counter = 0, rvalid = 0, rdata = 0, busy_err = 0, gnt = 0 and mem_wrEn = 0, regardless of req.
REQ-032 rst asserted mid-read SHALL suppress the pending rvalid; the first grant after rst deasserts SHALL follow REQ-020 with rr_ptr = 0.
REQ-033 busy_err SHALL clear only on rst.

Verification
REQ-034 req = 3'b111, lock = 0, all reads, 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100; rvalid is the same sequence delayed by 1 cycle.
REQ-035 req[1] = 1, wrEn[1] = 1, addr = 12'h005, dataIn = 48'hABC -> mem_wrEn = 1 at 12'h005 for one cycle; no rvalid; a subsequent read of 12'h005 returns 48'hABC with rvalid[1] one cycle after gnt.
REQ-036 req[0] = lock[0] = 1 for 5 cycles while req[1] = 1 -> gnt[0] for 5 cycles, gnt[1] = 0 throughout; gnt[1] asserts in the cycle lock[0] drops.
REQ-037 MAX_LOCK = 16, req[2] = lock[2] = 1 held and req[0] = 1 -> gnt[2] for exactly 16 cycles, then gnt[0] on cycle 17, and busy_err = 1 from then on.
REQ-038 rst pulsed in the cycle after a read grant to requester 1 -> no rvalid[1]; all outputs are 0 while rst is high; with req = 3'b110 after release, the first grant is 010.
